uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
- REQ-001: Parameter DIVISOR, default 1155, SHALL set the clock cycles per serial bit (133 MHz / 115200 baud); legal range 2..65535.
- REQ-002: Parameter FIFO_DEPTH, default 16, SHALL set the transmit FIFO entries; must be a power of two.
- REQ-003: clk  input  1  SHALL be the single clock for all logic (internal 133 MHz oscillator).
- REQ-004: i_RESET_N  input  1  SHALL be the reset: asynchronous assert, active-low, synchronous deassert in the owning top.
- REQ-005: i_WR_STB  input  1  SHALL be a one-cycle pulse from the 6809 bus decode requesting a write of i_WR_DATA.
- REQ-006: i_WR_DATA  input  8  SHALL be the byte to queue; sampled only when i_WR_STB=1.
- REQ-007: i_CTS_N  input  1  SHALL be FT2232 clear-to-send, active-low, asynchronous to clk.
- REQ-008: i_CLR_OVR  input  1  SHALL be a one-cycle pulse clearing o_OVERRUN.
- REQ-009: o_TX  output  1  SHALL be the serial line to FT2232 RX; idle high.
- REQ-010: o_FULL  output  1  SHALL be high when FIFO count = FIFO_DEPTH.
- REQ-011: o_EMPTY  output  1  SHALL be high when FIFO count = 0.
- REQ-012: o_COUNT  output  log2(FIFO_DEPTH)+1  SHALL be the current FIFO occupancy.
- REQ-013: o_BUSY  output  1  SHALL be high when the FSM is not IDLE or the FIFO is non-empty.
- REQ-014: o_OVERRUN  output  1  SHALL be a sticky flag set by a write to a full FIFO.

Function
- REQ-015: Frame SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), each exactly DIVISOR clk cycles.
- REQ-016: FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on pop; START->DATA after DIVISOR cycles; DATA->STOP after 8th bit; STOP->IDLE after DIVISOR cycles.
- REQ-017: In IDLE, a pop SHALL occur on the clock edge where FIFO non-empty and synchronized CTS low; o_TX SHALL go low in the cycle after the pop.
- REQ-018: With FIFO empty, IDLE and CTS already synchronized low, o_TX SHALL fall 2 cycles after the edge sampling i_WR_STB.
- REQ-019: i_CTS_N SHALL pass through a 2-flop synchronizer; CTS is evaluated only in IDLE; deassertion mid-frame SHALL NOT abort or stretch the frame.
- REQ-020: Back-to-back frames SHALL have no idle gap: STOP->IDLE->START costs exactly one extra clk cycle beyond the stop bit.
- REQ-021: Bit counter SHALL be 3 bits; baud counter SHALL count DIVISOR-1 down to 0 and reload; no fractional correction.
- REQ-022: Write when o_FULL=1 SHALL be dropped and set o_OVERRUN, even if a pop occurs the same cycle; count updates for the pop only.
- REQ-023: Simultaneous accepted write and pop SHALL leave o_COUNT unchanged and preserve byte order.
- REQ-024: FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH with no loss of data.
- REQ-025: i_CLR_OVR and an overrunning write in the same cycle SHALL leave o_OVERRUN set.
- REQ-026: All outputs SHALL be registered except o_FULL, o_EMPTY, o_BUSY, which may be decoded from registered state.

Reset
- REQ-027: On i_RESET_N low, immediately and regardless of clk: o_TX=1, FSM=IDLE, FIFO pointers=0, o_COUNT=0, o_EMPTY=1, o_FULL=0, o_BUSY=0, o_OVERRUN=0, CTS synchronizer=1 (not clear).
- REQ-028: Reset mid-frame SHALL abandon the frame and discard all queued bytes; first frame after release SHALL be a complete frame.

Verification (DIVISOR=4, FIFO_DEPTH=16)
- REQ-029: CTS low, write 0xA5 -> o_TX low 2 cycles after strobe, then bits 1,0,1,0,0,1,0,1, stop 1, 4 cycles each; o_BUSY falls after stop.
- REQ-030: CTS high, write 17 bytes -> o_COUNT=16, o_FULL=1, o_OVERRUN=1, o_TX stays 1; CTS low -> 16 frames in write order, no gaps beyond 1 cycle.
- REQ-031: Deassert CTS during DATA of frame 1 with 3 queued -> frame 1 completes intact; frames 2-3 held until CTS low again (+2 sync cycles).
- REQ-032: Steady write-one/pop-one for 40 bytes -> pointers wrap twice, serial output matches input sequence exactly.
- REQ-033: Assert i_RESET_N low mid-DATA with 5 queued -> o_TX=1 same cycle, o_COUNT=0, o_OVERRUN=0; post-release write 0x3C transmits cleanly.
- REQ-034: Pulse i_CLR_OVR with o_OVERRUN=1 -> cleared next cycle; same-cycle overrunning write -> remains 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO, with CTS flow control.
// Serial output is registered from the FSM state, so o_TX lags the state by one clock.
module uart_tx_fifo #(
    parameter int DIVISOR    = 1155,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          i_RESET_N,
    input  logic                          i_WR_STB,
    input  logic [7:0]                    i_WR_DATA,
    input  logic                          i_CTS_N,
    input  logic                          i_CLR_OVR,
    output logic                          o_TX,
    output logic                          o_FULL,
    output logic                          o_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   o_COUNT,
    output logic                          o_BUSY,
    output logic                          o_OVERRUN
);

    localparam int             AW          = $clog2(FIFO_DEPTH);
    localparam int             CW          = AW + 1;
    localparam logic [15:0]    BAUD_RELOAD = 16'(DIVISOR - 1);
    localparam logic [CW-1:0]  DEPTH_C     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovr_q, ovr_d;
    logic            cts_meta_q, cts_sync_q;
    logic [7:0]      mem [FIFO_DEPTH];

    logic            full, empty, wr_acc, pop;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign wr_acc = i_WR_STB && !full;
    // CTS only gates the start of a new frame; a frame in flight always completes.
    assign pop    = (state_q == S_IDLE) && !empty && !cts_sync_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d = S_START;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    shift_d = mem[rptr_q];
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_q == 16'd0) begin
                    state_d = S_DATA;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (baud_q == 16'd0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        if (wr_acc) wptr_d = wptr_q + AW'(1);
        if (pop)    rptr_d = rptr_q + AW'(1);
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A dropped write wins over a same-cycle clear.
        if (i_WR_STB && full)  ovr_d = 1'b1;
        else if (i_CLR_OVR)    ovr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            cts_meta_q <= i_CTS_N;
            cts_sync_q <= cts_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (wr_acc) mem[wptr_q] <= i_WR_DATA;
    end

    assign o_TX      = tx_q;
    assign o_FULL    = full;
    assign o_EMPTY   = empty;
    assign o_COUNT   = count_q;
    assign o_BUSY    = (state_q != S_IDLE) || !empty;
    assign o_OVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIVISOR=4, FIFO_DEPTH=16; decodes the serial line
// mid-bit on falling clock edges and compares against hand-derived bytes and timings.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       i_RESET_N = 1'b0;
    logic       i_WR_STB = 1'b0;
    logic [7:0] i_WR_DATA = 8'h00;
    logic       i_CTS_N = 1'b1;
    logic       i_CLR_OVR = 1'b0;
    logic       o_TX, o_FULL, o_EMPTY, o_BUSY, o_OVERRUN;
    logic [4:0] o_COUNT;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    uart_tx_fifo #(.DIVISOR(4), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .i_RESET_N (i_RESET_N),
        .i_WR_STB  (i_WR_STB),
        .i_WR_DATA (i_WR_DATA),
        .i_CTS_N   (i_CTS_N),
        .i_CLR_OVR (i_CLR_OVR),
        .o_TX      (o_TX),
        .o_FULL    (o_FULL),
        .o_EMPTY   (o_EMPTY),
        .o_COUNT   (o_COUNT),
        .o_BUSY    (o_BUSY),
        .o_OVERRUN (o_OVERRUN)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wr_byte(input logic [7:0] d);
        @(negedge clk);
        i_WR_STB  = 1'b1;
        i_WR_DATA = d;
        @(negedge clk);
        i_WR_STB  = 1'b0;
    endtask

    // Waits for a start bit, then samples each bit 1.5 clocks into its 4-clock cell.
    task automatic rx_frame(input logic [7:0] exp, output int fall);
        int n;
        logic [7:0] b;
        n = 0;
        b = 8'h00;
        while (o_TX !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rx_detect", o_TX, 0);
        fall = cyc;
        @(negedge clk);
        chk("rx_start", o_TX, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = o_TX;
        end
        repeat (4) @(negedge clk);
        chk("rx_stop", o_TX, 1);
        chk("rx_data", b, exp);
    endtask

    initial begin
        int fall_c, prev_c;
        logic [7:0] v;

        // Reset state, reset held low from time zero
        #12;
        chk("rst_tx", o_TX, 1);
        chk("rst_empty", o_EMPTY, 1);
        chk("rst_full", o_FULL, 0);
        chk("rst_count", o_COUNT, 0);
        chk("rst_busy", o_BUSY, 0);
        chk("rst_ovr", o_OVERRUN, 0);
        @(negedge clk);
        i_RESET_N = 1'b1;
        i_CTS_N   = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte 0xA5: line falls two clocks after the sampling edge
        wr_byte(8'hA5);
        chk("a5_pre0", o_TX, 1);
        @(negedge clk);
        chk("a5_pre1", o_TX, 1);
        @(negedge clk);
        chk("a5_fall", o_TX, 0);
        rx_frame(8'hA5, fall_c);
        chk("a5_busy_stop", o_BUSY, 1);
        repeat (3) @(negedge clk);
        chk("a5_busy_end", o_BUSY, 0);
        chk("a5_idle_tx", o_TX, 1);

        // CTS high: fill with 17 bytes, 17th overruns
        i_CTS_N = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            i_WR_STB  = 1'b1;
            i_WR_DATA = 8'(i * 37 + 3);
        end
        @(negedge clk);
        i_WR_STB = 1'b0;
        chk("fill_count", o_COUNT, 16);
        chk("fill_full", o_FULL, 1);
        chk("fill_empty", o_EMPTY, 0);
        chk("fill_ovr", o_OVERRUN, 1);
        repeat (10) @(negedge clk);
        chk("fill_tx_held", o_TX, 1);

        // Clear collides with an overrunning write, then a clear on its own
        i_WR_STB  = 1'b1;
        i_WR_DATA = 8'hFF;
        i_CLR_OVR = 1'b1;
        @(negedge clk);
        i_WR_STB  = 1'b0;
        i_CLR_OVR = 1'b0;
        chk("clr_collide_ovr", o_OVERRUN, 1);
        chk("clr_collide_count", o_COUNT, 16);
        i_CLR_OVR = 1'b1;
        @(negedge clk);
        i_CLR_OVR = 1'b0;
        chk("clr_ovr", o_OVERRUN, 0);

        // Drain 16 frames back to back: 41 clocks between start edges
        i_CTS_N = 1'b0;
        prev_c = 0;
        for (int i = 0; i < 16; i++) begin
            rx_frame(8'(i * 37 + 3), fall_c);
            if (i > 0) chk("drain_gap", fall_c - prev_c, 41);
            prev_c = fall_c;
        end
        repeat (10) @(negedge clk);
        chk("drain_empty", o_EMPTY, 1);
        chk("drain_busy", o_BUSY, 0);

        // CTS dropped mid-frame with 3 queued; a write coincides with the first pop
        i_CTS_N = 1'b1;
        repeat (3) @(negedge clk);
        wr_byte(8'h11);
        wr_byte(8'h22);
        wr_byte(8'h33);
        chk("cts_q3", o_COUNT, 3);
        i_CTS_N = 1'b0;
        @(negedge clk);
        chk("cts_sync1", o_TX, 1);
        @(negedge clk);
        chk("cts_sync2", o_TX, 1);
        i_WR_STB  = 1'b1;
        i_WR_DATA = 8'h44;
        @(negedge clk);
        i_WR_STB = 1'b0;
        chk("wrpop_count", o_COUNT, 3);
        chk("cts_sync3", o_TX, 1);
        @(negedge clk);
        chk("cts_fall", o_TX, 0);
        fork
            rx_frame(8'h11, fall_c);
            begin
                repeat (10) @(negedge clk);
                i_CTS_N = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        chk("cts_hold_tx", o_TX, 1);
        chk("cts_hold_count", o_COUNT, 3);
        i_CTS_N = 1'b0;
        repeat (3) @(negedge clk);
        chk("cts_resume_pre", o_TX, 1);
        @(negedge clk);
        chk("cts_resume_fall", o_TX, 0);
        rx_frame(8'h22, fall_c);
        rx_frame(8'h33, fall_c);
        rx_frame(8'h44, fall_c);
        repeat (6) @(negedge clk);

        // 40 bytes write-one/send-one: both pointers wrap twice
        for (int i = 0; i < 40; i++) begin
            v = 8'(i * 53 + 9);
            wr_byte(v);
            rx_frame(v, fall_c);
        end
        repeat (6) @(negedge clk);
        chk("wrap_empty", o_EMPTY, 1);

        // Reset mid-DATA with 5 queued
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            i_WR_STB  = 1'b1;
            i_WR_DATA = 8'h00;
        end
        @(negedge clk);
        i_WR_STB = 1'b0;
        chk("mid_q5", o_COUNT, 5);
        repeat (12) @(negedge clk);
        chk("mid_tx_low", o_TX, 0);
        #2;
        i_RESET_N = 1'b0;
        #1;
        chk("mid_rst_tx", o_TX, 1);
        chk("mid_rst_count", o_COUNT, 0);
        chk("mid_rst_empty", o_EMPTY, 1);
        chk("mid_rst_busy", o_BUSY, 0);
        chk("mid_rst_ovr", o_OVERRUN, 0);
        @(negedge clk);
        @(negedge clk);
        i_RESET_N = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_tx", o_TX, 1);
        wr_byte(8'h3C);
        rx_frame(8'h3C, fall_c);
        repeat (10) @(negedge clk);
        chk("post_rst_busy", o_BUSY, 0);
        chk("post_rst_tx_idle", o_TX, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
